// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared word type, FSM encoding and timing constants for mem_master
package mem_master_pkg;
    typedef logic [15:0] word_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int TIMEOUT_DEF = 16;
    localparam int MEM_DELAY = 4;
endpackage

// File: rtl/mem_master_if.sv
// mem_master_if: memory-side strobe/mfc bus between mem_master and the memory
interface mem_master_if;
    import mem_master_pkg::*;
    logic  strobe;
    logic  rnotw;
    word_t addr;
    word_t wdata;
    logic  mfc;
    word_t rdata;
    modport master (output strobe, rnotw, addr, wdata, input mfc, rdata);
    modport slave (input strobe, rnotw, addr, wdata, output mfc, rdata);
endinterface

// File: rtl/mem_rr_arb.sv
// mem_rr_arb: two-client round-robin grant, favouring the client not granted last
module mem_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    assign grant = (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_master.sv
// mem_master: two-client arbitrated memory master with read timeout and registered outputs
module mem_master
    import mem_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic c0_req,
    input  logic c1_req,
    input  logic c0_rnotw,
    input  logic c1_rnotw,
    input  word_t c0_addr,
    input  word_t c1_addr,
    input  word_t c0_wdata,
    input  word_t c1_wdata,
    output logic c0_done,
    output logic c1_done,
    output word_t rd_data,
    output logic err,
    mem_master_if.master bus
);
    state_t     state_q, state_d;
    logic       strobe_q, strobe_d;
    logic       rnotw_q, rnotw_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    word_t      rd_data_q, rd_data_d;
    logic       err_q, err_d;
    logic       c0_done_q, c0_done_d;
    logic       c1_done_q, c1_done_d;
    logic [4:0] cnt_q, cnt_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] grant;

    mem_rr_arb u_arb (
        .req       ({c1_req, c0_req}),
        .last_grant(last_grant_q),
        .grant     (grant)
    );

    always_comb begin
        state_d      = state_q;
        strobe_d     = 1'b0;
        rnotw_d      = rnotw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        err_d        = err_q;
        c0_done_d    = 1'b0;
        c1_done_d    = 1'b0;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: if (|grant) begin
                state_d      = ISSUE;
                strobe_d     = 1'b1;
                last_grant_d = grant[1];
                rnotw_d      = grant[1] ? c1_rnotw : c0_rnotw;
                addr_d       = grant[1] ? c1_addr : c0_addr;
                wdata_d      = grant[1] ? c1_wdata : c0_wdata;
            end
            ISSUE: begin
                state_d   = rnotw_q ? WAIT : DONE;
                cnt_d     = '0;
                rd_data_d = rnotw_q ? rd_data_q : '0;
                err_d     = rnotw_q ? err_q : 1'b0;
            end
            WAIT: begin
                // mfc wins over a timeout landing on the same edge
                if (bus.mfc) begin
                    state_d   = DONE;
                    rd_data_d = bus.rdata;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == 5'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    rd_data_d = '0;
                    err_d     = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                c0_done_d = !last_grant_q;
                c1_done_d = last_grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            strobe_q     <= 1'b0;
            rnotw_q      <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
            c0_done_q    <= 1'b0;
            c1_done_q    <= 1'b0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            strobe_q     <= strobe_d;
            rnotw_q      <= rnotw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
            c0_done_q    <= c0_done_d;
            c1_done_q    <= c1_done_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.strobe = strobe_q;
    assign bus.rnotw  = rnotw_q;
    assign bus.addr   = addr_q;
    assign bus.wdata  = wdata_q;
    assign rd_data    = rd_data_q;
    assign err        = err_q;
    assign c0_done    = c0_done_q;
    assign c1_done    = c1_done_q;
endmodule
